// File: rtl/sram_arb2.sv
// Two-master round-robin arbiter in front of the single-port SRAM controller.
// Commands and responses pass through combinationally; a 2-entry ID FIFO records ownership.
module sram_arb2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cmd_vld,
  output logic              m0_cmd_rdy,
  input  logic [AW-1:0]     m0_cmd_addr,
  input  logic              m0_cmd_read,
  input  logic [DW-1:0]     m0_cmd_wdata,
  input  logic [DW/8-1:0]   m0_cmd_wmask,
  output logic              m0_rsp_vld,
  input  logic              m0_rsp_rdy,
  output logic              m0_rsp_err,
  output logic [DW-1:0]     m0_rsp_rdata,
  input  logic              m1_cmd_vld,
  output logic              m1_cmd_rdy,
  input  logic [AW-1:0]     m1_cmd_addr,
  input  logic              m1_cmd_read,
  input  logic [DW-1:0]     m1_cmd_wdata,
  input  logic [DW/8-1:0]   m1_cmd_wmask,
  output logic              m1_rsp_vld,
  input  logic              m1_rsp_rdy,
  output logic              m1_rsp_err,
  output logic [DW-1:0]     m1_rsp_rdata,
  output logic              sram_cmd_vld,
  input  logic              sram_cmd_rdy,
  output logic [AW-1:0]     sram_cmd_addr,
  output logic              sram_cmd_read,
  output logic [DW-1:0]     sram_cmd_wdata,
  output logic [DW/8-1:0]   sram_cmd_wmask,
  input  logic              sram_rsp_vld,
  output logic              sram_rsp_rdy,
  input  logic              sram_rsp_err,
  input  logic [DW-1:0]     sram_rsp_rdata,
  output logic              arb_orphan
);

  logic       prio_q, prio_d;
  logic [1:0] fifo_q, fifo_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       orphan_q, orphan_d;

  logic       can_issue_s;
  logic       win_s;
  logic       issue_s;
  logic       pop_s;
  logic       head_s;

  // Command arbitration and mux; nothing is offered to the controller while reset is held.
  always_comb begin
    can_issue_s = rst & (count_q != 2'd2);
    if (m0_cmd_vld & m1_cmd_vld) begin
      win_s = prio_q;
    end else if (m1_cmd_vld) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    sram_cmd_vld = can_issue_s & (m0_cmd_vld | m1_cmd_vld);
    if (win_s) begin
      sram_cmd_addr  = m1_cmd_addr;
      sram_cmd_read  = m1_cmd_read;
      sram_cmd_wdata = m1_cmd_wdata;
      sram_cmd_wmask = m1_cmd_wmask;
    end else begin
      sram_cmd_addr  = m0_cmd_addr;
      sram_cmd_read  = m0_cmd_read;
      sram_cmd_wdata = m0_cmd_wdata;
      sram_cmd_wmask = m0_cmd_wmask;
    end
    issue_s    = sram_cmd_vld & sram_cmd_rdy;
    m0_cmd_rdy = issue_s & ~win_s;
    m1_cmd_rdy = issue_s & win_s;
  end

  // Response steering to the owner at the FIFO head; with nothing outstanding, drain strays.
  always_comb begin
    head_s       = fifo_q[rd_ptr_q];
    m0_rsp_vld   = 1'b0;
    m1_rsp_vld   = 1'b0;
    sram_rsp_rdy = 1'b1;
    if (count_q != 2'd0) begin
      if (head_s) begin
        m1_rsp_vld   = sram_rsp_vld;
        sram_rsp_rdy = m1_rsp_rdy;
      end else begin
        m0_rsp_vld   = sram_rsp_vld;
        sram_rsp_rdy = m0_rsp_rdy;
      end
    end else begin
      sram_rsp_rdy = 1'b1;
    end
    m0_rsp_rdata = sram_rsp_rdata;
    m1_rsp_rdata = sram_rsp_rdata;
    m0_rsp_err   = sram_rsp_err;
    m1_rsp_err   = sram_rsp_err;
    pop_s        = sram_rsp_vld & sram_rsp_rdy & (count_q != 2'd0);
  end

  // Next state for priority, ownership FIFO and the orphan flag.
  always_comb begin
    prio_d   = prio_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    orphan_d = orphan_q | (sram_rsp_vld & (count_q == 2'd0));
    if (issue_s) begin
      fifo_d[wr_ptr_q] = win_s;
      wr_ptr_d         = ~wr_ptr_q;
      prio_d           = ~win_s;
    end else begin
      prio_d = prio_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({issue_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_q   <= 1'b0;
      fifo_q   <= 2'b00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      orphan_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      orphan_q <= orphan_d;
    end
  end

  assign arb_orphan = orphan_q;

endmodule

// File: tb/tb_sram_arb2.sv
// Bench for sram_arb2: directed vector table, hand-written reset sequences,
// then random traffic checked against a queue-based ownership model.
module tb_sram_arb2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic clk, rst;
  logic m0_cmd_vld, m0_cmd_rdy, m0_cmd_read, m0_rsp_vld, m0_rsp_rdy, m0_rsp_err;
  logic m1_cmd_vld, m1_cmd_rdy, m1_cmd_read, m1_rsp_vld, m1_rsp_rdy, m1_rsp_err;
  logic [AW-1:0] m0_cmd_addr, m1_cmd_addr, sram_cmd_addr;
  logic [DW-1:0] m0_cmd_wdata, m1_cmd_wdata, sram_cmd_wdata;
  logic [MW-1:0] m0_cmd_wmask, m1_cmd_wmask, sram_cmd_wmask;
  logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata, sram_rsp_rdata;
  logic sram_cmd_vld, sram_cmd_rdy, sram_cmd_read;
  logic sram_rsp_vld, sram_rsp_rdy, sram_rsp_err, arb_orphan;

  int errors = 0;
  int checks = 0;

  sram_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_cmd_vld(m0_cmd_vld), .m0_cmd_rdy(m0_cmd_rdy), .m0_cmd_addr(m0_cmd_addr),
    .m0_cmd_read(m0_cmd_read), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_err(m0_rsp_err),
    .m0_rsp_rdata(m0_rsp_rdata),
    .m1_cmd_vld(m1_cmd_vld), .m1_cmd_rdy(m1_cmd_rdy), .m1_cmd_addr(m1_cmd_addr),
    .m1_cmd_read(m1_cmd_read), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_err(m1_rsp_err),
    .m1_rsp_rdata(m1_rsp_rdata),
    .sram_cmd_vld(sram_cmd_vld), .sram_cmd_rdy(sram_cmd_rdy), .sram_cmd_addr(sram_cmd_addr),
    .sram_cmd_read(sram_cmd_read), .sram_cmd_wdata(sram_cmd_wdata),
    .sram_cmd_wmask(sram_cmd_wmask),
    .sram_rsp_vld(sram_rsp_vld), .sram_rsp_rdy(sram_rsp_rdy), .sram_rsp_err(sram_rsp_err),
    .sram_rsp_rdata(sram_rsp_rdata), .arb_orphan(arb_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic m0v, m1v; logic [31:0] m0a, m1a; logic m0r, m1r;
    logic [31:0] m1wd; logic [3:0] m1wm; logic crdy, rvld; logic [31:0] rdata;
    logic m0rr, m1rr;
    logic e_cvld; logic [31:0] e_addr; logic e_read; logic [31:0] e_wd; logic [3:0] e_wm;
    logic e_m0rdy, e_m1rdy, e_m0rv, e_m1rv, e_srr, e_orph;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_cmd_vld = 1'b0; m0_cmd_addr = 32'h0; m0_cmd_read = 1'b1; m0_cmd_wdata = 32'h0;
    m0_cmd_wmask = 4'hF; m1_cmd_vld = 1'b0; m1_cmd_addr = 32'h0; m1_cmd_read = 1'b1;
    m1_cmd_wdata = 32'h0; m1_cmd_wmask = 4'h0; sram_cmd_rdy = 1'b1; sram_rsp_vld = 1'b0;
    sram_rsp_err = 1'b0; sram_rsp_rdata = 32'h0; m0_rsp_rdy = 1'b1; m1_rsp_rdy = 1'b1;
  endtask

  task automatic rand_inputs();
    m0_cmd_vld = 1'($urandom_range(0, 1)); m0_cmd_addr = $urandom; m0_cmd_read = 1'($urandom_range(0, 1));
    m0_cmd_wdata = $urandom; m0_cmd_wmask = 4'($urandom_range(0, 15));
    m1_cmd_vld = 1'($urandom_range(0, 1)); m1_cmd_addr = $urandom; m1_cmd_read = 1'($urandom_range(0, 1));
    m1_cmd_wdata = $urandom; m1_cmd_wmask = 4'($urandom_range(0, 15));
    sram_cmd_rdy = 1'($urandom_range(0, 1)); sram_rsp_vld = 1'($urandom_range(0, 1));
    sram_rsp_err = 1'($urandom_range(0, 1)); sram_rsp_rdata = $urandom;
    m0_rsp_rdy = 1'($urandom_range(0, 1)); m1_rsp_rdy = 1'($urandom_range(0, 1));
  endtask

  // Reset held low with random inputs: nothing may be issued or routed.
  task automatic reset_check(input string tag);
    rst = 1'b0;
    rand_inputs();
    #1;
    chk({tag, " cmd_vld"}, sram_cmd_vld, 1'b0);
    chk({tag, " m0_rsp_vld"}, m0_rsp_vld, 1'b0);
    chk({tag, " m1_rsp_vld"}, m1_rsp_vld, 1'b0);
    chk({tag, " sram_rsp_rdy"}, sram_rsp_rdy, 1'b1);
    chk({tag, " orphan"}, arb_orphan, 1'b0);
  endtask

  initial begin
    bit mq[$];
    bit mprio, morph, pend0, pend1;
    bit win, e_cvld, e_m0rdy, e_m1rdy, e_m0rv, e_m1rv, e_srr, issue, pop;

    tv[0]  = '{1'b1,1'b0,32'h100,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b0,32'h0,1'b1,1'b1, 1'b1,32'h100,1'b1,32'h0,4'hF,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
    tv[1]  = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'hDEADBEEF,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[2]  = '{1'b0,1'b1,32'h0,32'h40,1'b1,1'b0,32'h12345678,4'h3,1'b1,1'b0,32'h0,1'b1,1'b1, 1'b1,32'h40,1'b0,32'h12345678,4'h3,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
    tv[3]  = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h0,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    tv[4]  = '{1'b1,1'b1,32'h200,32'h300,1'b1,1'b1,32'h0,4'h0,1'b1,1'b0,32'h0,1'b1,1'b1, 1'b1,32'h200,1'b1,32'h0,4'hF,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0};
    tv[5]  = '{1'b1,1'b1,32'h200,32'h300,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'hA5,1'b1,1'b1, 1'b1,32'h300,1'b1,32'h0,4'h0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};
    tv[6]  = '{1'b1,1'b1,32'h200,32'h300,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h5A,1'b1,1'b1, 1'b1,32'h200,1'b1,32'h0,4'hF,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0};
    tv[7]  = '{1'b1,1'b1,32'h200,32'h300,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h77,1'b1,1'b1, 1'b1,32'h300,1'b1,32'h0,4'h0,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0};
    tv[8]  = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h88,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    tv[9]  = '{1'b0,1'b1,32'h0,32'h500,1'b1,1'b1,32'h0,4'h0,1'b1,1'b0,32'h0,1'b1,1'b1, 1'b1,32'h500,1'b1,32'h0,4'h0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
    tv[10] = '{1'b1,1'b0,32'h600,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h99,1'b1,1'b0, 1'b1,32'h600,1'b1,32'h0,4'hF,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
    tv[11] = '{1'b1,1'b1,32'h700,32'h800,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h99,1'b1,1'b0, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    tv[12] = '{1'b1,1'b1,32'h700,32'h800,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h99,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
    tv[13] = '{1'b1,1'b1,32'h700,32'h800,1'b1,1'b1,32'h0,4'h0,1'b1,1'b0,32'h0,1'b1,1'b1, 1'b1,32'h800,1'b1,32'h0,4'h0,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
    tv[14] = '{1'b1,1'b0,32'h700,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h11,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[15] = '{1'b1,1'b0,32'h700,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h22,1'b1,1'b1, 1'b1,32'h700,1'b1,32'h0,4'hF,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0};
    tv[16] = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h33,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
    tv[17] = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b1,32'h44,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    tv[18] = '{1'b0,1'b0,32'h0,32'h0,1'b1,1'b1,32'h0,4'h0,1'b1,1'b0,32'h0,1'b1,1'b1, 1'b0,32'h0,1'b0,32'h0,4'h0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};

    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    reset_check("reset");
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      m0_cmd_vld = tv[i].m0v; m1_cmd_vld = tv[i].m1v;
      m0_cmd_addr = tv[i].m0a; m1_cmd_addr = tv[i].m1a;
      m0_cmd_read = tv[i].m0r; m1_cmd_read = tv[i].m1r;
      m0_cmd_wdata = 32'h0; m0_cmd_wmask = 4'hF;
      m1_cmd_wdata = tv[i].m1wd; m1_cmd_wmask = tv[i].m1wm;
      sram_cmd_rdy = tv[i].crdy; sram_rsp_vld = tv[i].rvld; sram_rsp_rdata = tv[i].rdata;
      sram_rsp_err = 1'b0; m0_rsp_rdy = tv[i].m0rr; m1_rsp_rdy = tv[i].m1rr;
      #1;
      chk($sformatf("v%0d cmd_vld", i), sram_cmd_vld, tv[i].e_cvld);
      if (tv[i].e_cvld) begin
        chk($sformatf("v%0d addr", i), sram_cmd_addr, tv[i].e_addr);
        chk($sformatf("v%0d read", i), sram_cmd_read, tv[i].e_read);
        chk($sformatf("v%0d wdata", i), sram_cmd_wdata, tv[i].e_wd);
        chk($sformatf("v%0d wmask", i), sram_cmd_wmask, tv[i].e_wm);
      end
      chk($sformatf("v%0d m0_cmd_rdy", i), m0_cmd_rdy, tv[i].e_m0rdy);
      chk($sformatf("v%0d m1_cmd_rdy", i), m1_cmd_rdy, tv[i].e_m1rdy);
      chk($sformatf("v%0d m0_rsp_vld", i), m0_rsp_vld, tv[i].e_m0rv);
      chk($sformatf("v%0d m1_rsp_vld", i), m1_rsp_vld, tv[i].e_m1rv);
      chk($sformatf("v%0d sram_rsp_rdy", i), sram_rsp_rdy, tv[i].e_srr);
      chk($sformatf("v%0d orphan", i), arb_orphan, tv[i].e_orph);
      if (tv[i].e_m0rv) chk($sformatf("v%0d m0_rdata", i), m0_rsp_rdata, tv[i].rdata);
      if (tv[i].e_m1rv) chk($sformatf("v%0d m1_rdata", i), m1_rsp_rdata, tv[i].rdata);
      @(negedge clk);
    end

    // The orphan flag must clear asynchronously, without waiting for a clock edge.
    rst = 1'b0;
    #1;
    chk("async_rst orphan", arb_orphan, 1'b0);
    @(negedge clk);
    reset_check("reset2");

    // Mid-operation reset: the in-flight response comes back unowned and is drained.
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    m0_cmd_vld = 1'b1; m0_cmd_addr = 32'h900;
    #1;
    chk("midrst issue", m0_cmd_rdy, 1'b1);
    @(negedge clk);
    m0_cmd_vld = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sram_rsp_vld = 1'b1; sram_rsp_rdata = 32'hCAFE;
    #1;
    chk("midrst m0_rsp_vld", m0_rsp_vld, 1'b0);
    chk("midrst sram_rsp_rdy", sram_rsp_rdy, 1'b1);
    @(negedge clk);
    sram_rsp_vld = 1'b0;
    #1;
    chk("midrst orphan", arb_orphan, 1'b1);

    // Random traffic against an ownership-queue model.
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    mq.delete(); mprio = 1'b0; morph = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic k0v, k1v, k0r, k1r;
      logic [31:0] k0a, k1a, k0d, k1d;
      logic [3:0] k0m, k1m;
      k0v = m0_cmd_vld; k0a = m0_cmd_addr; k0r = m0_cmd_read; k0d = m0_cmd_wdata; k0m = m0_cmd_wmask;
      k1v = m1_cmd_vld; k1a = m1_cmd_addr; k1r = m1_cmd_read; k1d = m1_cmd_wdata; k1m = m1_cmd_wmask;
      rand_inputs();
      if (pend0) begin
        m0_cmd_vld = k0v; m0_cmd_addr = k0a; m0_cmd_read = k0r; m0_cmd_wdata = k0d; m0_cmd_wmask = k0m;
      end
      if (pend1) begin
        m1_cmd_vld = k1v; m1_cmd_addr = k1a; m1_cmd_read = k1r; m1_cmd_wdata = k1d; m1_cmd_wmask = k1m;
      end
      m0_rsp_rdy = ($urandom_range(0, 3) != 0);
      m1_rsp_rdy = ($urandom_range(0, 3) != 0);
      sram_cmd_rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      if (!rst) begin
        mq.delete(); mprio = 1'b0; morph = 1'b0;
      end
      #1;
      if (m0_cmd_vld && m1_cmd_vld) win = mprio;
      else win = m1_cmd_vld;
      e_cvld  = rst && (mq.size() < 2) && (m0_cmd_vld || m1_cmd_vld);
      e_m0rdy = e_cvld && sram_cmd_rdy && !win;
      e_m1rdy = e_cvld && sram_cmd_rdy && win;
      e_m0rv = 1'b0; e_m1rv = 1'b0; e_srr = 1'b1;
      if (mq.size() > 0) begin
        if (mq[0]) begin e_m1rv = sram_rsp_vld; e_srr = m1_rsp_rdy; end
        else begin e_m0rv = sram_rsp_vld; e_srr = m0_rsp_rdy; end
      end
      chk($sformatf("r%0d cmd_vld", c), sram_cmd_vld, e_cvld);
      if (e_cvld) begin
        chk($sformatf("r%0d addr", c), sram_cmd_addr, win ? m1_cmd_addr : m0_cmd_addr);
        chk($sformatf("r%0d read", c), sram_cmd_read, win ? m1_cmd_read : m0_cmd_read);
        chk($sformatf("r%0d wdata", c), sram_cmd_wdata, win ? m1_cmd_wdata : m0_cmd_wdata);
        chk($sformatf("r%0d wmask", c), sram_cmd_wmask, win ? m1_cmd_wmask : m0_cmd_wmask);
      end
      chk($sformatf("r%0d m0_cmd_rdy", c), m0_cmd_rdy, e_m0rdy);
      chk($sformatf("r%0d m1_cmd_rdy", c), m1_cmd_rdy, e_m1rdy);
      chk($sformatf("r%0d m0_rsp_vld", c), m0_rsp_vld, e_m0rv);
      chk($sformatf("r%0d m1_rsp_vld", c), m1_rsp_vld, e_m1rv);
      chk($sformatf("r%0d sram_rsp_rdy", c), sram_rsp_rdy, e_srr);
      chk($sformatf("r%0d orphan", c), arb_orphan, morph);
      if (e_m0rv) chk($sformatf("r%0d m0_rsp", c), {m0_rsp_err, m0_rsp_rdata}, {sram_rsp_err, sram_rsp_rdata});
      if (e_m1rv) chk($sformatf("r%0d m1_rsp", c), {m1_rsp_err, m1_rsp_rdata}, {sram_rsp_err, sram_rsp_rdata});
      pend0 = m0_cmd_vld && !e_m0rdy;
      pend1 = m1_cmd_vld && !e_m1rdy;
      if (rst) begin
        issue = e_cvld && sram_cmd_rdy;
        pop   = sram_rsp_vld && e_srr && (mq.size() > 0);
        if (sram_rsp_vld && mq.size() == 0) morph = 1'b1;
        if (pop) void'(mq.pop_front());
        if (issue) begin
          mq.push_back(win);
          mprio = !win;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_arb2.md
# sram_arb2

Two-master round-robin arbiter that sits directly upstream of the single-port SRAM controller. It merges the instruction-fetch port (m0) and the load/store port (m1) onto the controller's command channel. It tracks which master owns each outstanding command in a 2-entry ID FIFO, and steers each response back to its owner. The command and response paths are combinational pass-throughs; arbitration state and ownership tracking are registered.

## Interface
- AW, 32, address width
- DW, 32, data width; the write-mask width is DW/8

- clk  in  1  single clock; all registers update on its rising edge
- rst  in  1  asynchronous, active-low reset
- m0_cmd_vld / m1_cmd_vld  in  1  master command valid
- m0_cmd_rdy / m1_cmd_rdy  out  1  master command accepted
- m0_cmd_addr / m1_cmd_addr  in  AW  address
- m0_cmd_read / m1_cmd_read  in  1  1=read, 0=write
- m0_cmd_wdata / m1_cmd_wdata  in  DW  write data
- m0_cmd_wmask / m1_cmd_wmask  in  DW/8  byte-write mask
- m0_rsp_vld / m1_rsp_vld  out  1  response valid
- m0_rsp_rdy / m1_rsp_rdy  in  1  master ready for response
- m0_rsp_err / m1_rsp_err  out  1  response error
- m0_rsp_rdata / m1_rsp_rdata  out  DW  read data
- sram_cmd_vld  out  1  to controller
- sram_cmd_rdy  in  1  from controller
- sram_cmd_addr  out  AW  to controller
- sram_cmd_read  out  1  to controller
- sram_cmd_wdata  out  DW  to controller
- sram_cmd_wmask  out  DW/8  to controller
- sram_rsp_vld  in  1  from controller
- sram_rsp_rdy  out  1  to controller
- sram_rsp_err  in  1  from controller
- sram_rsp_rdata  in  DW  from controller
- arb_orphan  out  1  sticky flag: a response arrived with no owner recorded

## Operation
- **Registered state:**
  - prio: 0 means m0 has priority, 1 means m1 has priority.
  - ID FIFO: 2 entries of 1 bit each, with wr_ptr, rd_ptr and a 2-bit count.
  - arb_orphan.
- **Arbitration (combinational):**
  - can_issue = (count != 2).
  - If only one master is valid, it wins.
  - If both masters are valid, the master selected by prio wins.
  - sram_cmd_vld = can_issue & (m0_cmd_vld | m1_cmd_vld).
  - The command mux selects the winner's addr, read, wdata and wmask.
  - winner_cmd_rdy = sram_cmd_rdy & can_issue; the loser's cmd_rdy = 0.
- **Issue handshake:** issue = sram_cmd_vld & sram_cmd_rdy. On issue:
  - Push the winner's ID into the FIFO.
  - Set prio to the other master, so the last-served master gets lowest priority.
- **prio holds when there is no issue.** This applies even if a master is valid but stalled.
- **Full rule:** when count == 2, no push is allowed, even if a pop occurs in the same cycle. Commands stall until the next cycle.
- **Response routing (combinational), with head = FIFO[rd_ptr]:**
  - If count != 0:
    - m{head}_rsp_vld = sram_rsp_vld.
    - sram_rsp_rdy = m{head}_rsp_rdy.
    - The other master's rsp_vld = 0.
  - If count == 0: both rsp_vld = 0 and sram_rsp_rdy = 1, so any stray response is drained.
  - rsp_rdata and rsp_err are broadcast to both masters; they are meaningful only while that master's rsp_vld is high.
- **Pop:** pop = sram_rsp_vld & sram_rsp_rdy & (count != 0).
- **Orphan:** if sram_rsp_vld is high while count == 0, set arb_orphan. It clears only on reset.
- **Count update:**
  - count += 1 on push only.
  - count -= 1 on pop only.
  - count is unchanged on simultaneous push and pop.
- **Pointer wrap:** the pointers are 1 bit wide and wrap naturally.
- **Writes also produce a response from the controller.** That response is routed and must be accepted like a read response.

## Timing
- **Reset values** (asserted asynchronously):
  - prio=0, count=0, wr_ptr=0, rd_ptr=0, arb_orphan=0.
  - Resulting outputs: sram_cmd_vld=0, m0_rsp_vld=m1_rsp_vld=0, sram_rsp_rdy=1, and m*_cmd_rdy=0 while no master is valid.
- **Zero added latency in either path.** A command presented in cycle t reaches the controller in cycle t. The controller's response at t+1 or later is visible to the owner in the same cycle.
- **Back-to-back issue at one command per cycle is sustained** while the controller's response stage drains, because a push and a pop in the same cycle keep count at 1.
- **Responses are returned in issue order**; no reordering is possible.
- **Reset mid-operation:** the FIFO is flushed and any in-flight response is then drained via the count == 0 path. That drained response sets arb_orphan, which is expected after a mid-operation reset.
- **Master handshake rule:** a master holding cmd_vld must keep its command stable until cmd_rdy. The arbiter may switch the winner only after an issue.

## Test plan
- **Reset:** hold rst=0 with random inputs -> sram_cmd_vld=0, both rsp_vld=0, sram_rsp_rdy=1, arb_orphan=0.
- **Single master:**
  - m0 reads 0x100 with sram_cmd_rdy=1 -> the controller sees addr 0x100 with read=1 the same cycle.
  - The next-cycle response with rdata 0xDEADBEEF -> m0_rsp_vld=1 with that data; m1_rsp_vld=0.
- **Contention:** m0 and m1 both valid for 4 consecutive cycles with every response accepted -> grants alternate m0, m1, m0, m1, and responses route to the same owners in the same order.
- **Backpressure:**
  - Hold m1_rsp_rdy=0 on a pending m1 response -> sram_rsp_rdy=0 and the response stays valid.
  - Meanwhile issue 1 more command so count reaches 2 -> both cmd_rdy=0 until m1_rsp_rdy=1.
- **Write response:** m1 writes wdata 0x12345678, wmask 4'b0011 -> the controller receives both unchanged, and the write response pops the FIFO to m1.
- **Orphan:** force sram_rsp_vld=1 with count=0 -> sram_rsp_rdy=1, no master rsp_vld asserted, and arb_orphan=1 until reset.
